// File: rtl/truth_sweep2_if.sv
// Bus between truth_sweep2 and whoever drives it.
// Groups the sweep request/result signals together with the stimulus (x, y)
// and response (s1, s2) lines of the function block under test.
//   slave  : the sweeper itself (takes start, s1, s2; drives everything else)
//   master : the environment (drives start, s1, s2; observes results)
interface truth_sweep2_if;
    logic       start;
    logic       x;
    logic       y;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic [3:0] tt1;
    logic [3:0] tt2;
    logic [2:0] errs;
    logic       pass;

    modport slave (
        input  start, s1, s2,
        output x, y, busy, done, tt1, tt2, errs, pass
    );

    modport master (
        output start, s1, s2,
        input  x, y, busy, done, tt1, tt2, errs, pass
    );
endinterface

// File: rtl/truth_sweep2.sv
// truth_sweep2: sweeps {x,y} through 00,01,10,11 into a 2-in/2-out function
// block, captures its s1/s2 answers into 4-bit truth tables and compares them
// against EXP_S1/EXP_S2.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : truth_sweep2_if.slave
//            start (in)  sweep request, honoured only in IDLE
//            x, y (out)  stimulus, always equal to the current index
//            s1, s2 (in) function block outputs
//            busy (out)  high in WAIT
//            done (out)  one-cycle pulse at the end of a sweep
//            tt1, tt2    captured truth tables, bit i = answer for {x,y}=i
//            errs        number of indices with any mismatch (0..4)
//            pass        errs==0, updated when the sweep completes
//
// state | meaning
// IDLE  | waiting for start; last results held
// WAIT  | holding vector idx, counting down settle cycles, then sampling
// DONE  | one-cycle done pulse, then back to IDLE
module truth_sweep2 #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXP_S1 = 4'b1011,
    parameter logic [3:0]  EXP_S2 = 4'b1011
) (
    input  logic          clk,
    input  logic          rst_n,
    truth_sweep2_if.slave bus
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] tt1, tt1_nxt;
    logic [3:0] tt2, tt2_nxt;
    logic [2:0] errs, errs_nxt;
    logic       pass, pass_nxt;

    logic       miss;
    logic [2:0] errs_inc;

    // A mismatch on either output counts once for the index.
    assign miss     = (bus.s1 != EXP_S1[idx]) || (bus.s2 != EXP_S2[idx]);
    assign errs_inc = errs + {2'b00, miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= 8'd0;
            tt1   <= 4'd0;
            tt2   <= 4'd0;
            errs  <= 3'd0;
            pass  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            tt1   <= tt1_nxt;
            tt2   <= tt2_nxt;
            errs  <= errs_nxt;
            pass  <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        tt1_nxt   = tt1;
        tt2_nxt   = tt2;
        errs_nxt  = errs;
        pass_nxt  = pass;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_nxt   = 2'd0;
                    cnt_nxt   = SETTLE_C;
                    tt1_nxt   = 4'd0;
                    tt2_nxt   = 4'd0;
                    errs_nxt  = 3'd0;
                    pass_nxt  = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    tt1_nxt[idx] = bus.s1;
                    tt2_nxt[idx] = bus.s2;
                    errs_nxt     = errs_inc;
                    if (idx == 2'd3) begin
                        // Verdict includes the mismatch sampled on this edge.
                        pass_nxt  = (errs_inc == 3'd0);
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 2'd1;
                        cnt_nxt = SETTLE_C;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // x/y come straight from the index register; idx stays at 3 after a
    // sweep so the last vector is held until the next start.
    assign bus.x    = idx[1];
    assign bus.y    = idx[0];
    assign bus.busy = (state == WAIT);
    assign bus.done = (state == DONE);
    assign bus.tt1  = tt1;
    assign bus.tt2  = tt2;
    assign bus.errs = errs;
    assign bus.pass = pass;

endmodule

// File: tb/tb_truth_sweep2.sv
module tb_truth_sweep2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] m1 = 4'd0;
    logic [3:0] m2 = 4'd0;

    always #5 clk = ~clk;

    truth_sweep2_if if1 ();
    truth_sweep2_if if0 ();

    truth_sweep2 #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    truth_sweep2 #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    // Reference function block: s = !x | y (truth table 1011). Fault masks
    // m1/m2 flip the answer for selected indices.
    function automatic logic fxy(logic a, logic b);
        return !a | b;
    endfunction

    assign if1.start = start;
    assign if0.start = start;
    assign if1.s1 = fxy(if1.x, if1.y) ^ m1[{if1.x, if1.y}];
    assign if1.s2 = fxy(if1.x, if1.y) ^ m2[{if1.x, if1.y}];
    assign if0.s1 = fxy(if0.x, if0.y) ^ m1[{if0.x, if0.y}];
    assign if0.s2 = fxy(if0.x, if0.y) ^ m2[{if0.x, if0.y}];

    typedef struct {
        logic [3:0] tt1;
        logic [3:0] tt2;
        logic [2:0] errs;
        logic       pass;
        int         due;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   cyc = 0;
    int   rem1 = 0, rem0 = 0;
    int   c0_1 = 0, c0_0 = 0;
    bit   act1 = 1'b0, act0 = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic fail_now(string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t predict(logic [3:0] a, logic [3:0] b, int due);
        exp_t e;
        int   n;
        logic [1:0] v;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            e.tt1[i] = fxy(v[1], v[0]) ^ a[i];
            e.tt2[i] = fxy(v[1], v[0]) ^ b[i];
            if (a[i] | b[i]) n++;
        end
        e.errs = 3'(n);
        e.pass = (n == 0);
        e.due  = due;
        return e;
    endfunction

    // Expected {x,y,busy,done} given time since the accepted start.
    function automatic logic [3:0] stream_exp(bit act, int rel, int per);
        if (act && rel < 4 * per) return {2'(rel / per), 2'b10};
        if (act && rel == 4 * per) return 4'b1101;
        return {(act ? 2'b11 : 2'b00), 2'b00};
    endfunction

    // Predictor: a sweep occupies 4*(SETTLE+1) cycles plus one DONE cycle;
    // the sweeper accepts start on any edge where it is idle.
    initial begin : predictor
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q1.delete();
                q0.delete();
                rem1 = 0;
                rem0 = 0;
                act1 = 1'b0;
                act0 = 1'b0;
            end else begin
                cyc++;
                if (rem1 == 0) begin
                    if (start) begin
                        q1.push_back(predict(m1, m2, cyc + 8));
                        rem1 = 9;
                        c0_1 = cyc;
                        act1 = 1'b1;
                    end
                end else begin
                    rem1--;
                end
                if (rem0 == 0) begin
                    if (start) begin
                        q0.push_back(predict(m1, m2, cyc + 4));
                        rem0 = 5;
                        c0_0 = cyc;
                        act0 = 1'b1;
                    end
                end else begin
                    rem0--;
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp("s1 xy/busy/done", {28'd0, if1.x, if1.y, if1.busy, if1.done},
                    {28'd0, stream_exp(act1, cyc - c0_1, 2)});
                if (if1.done) begin
                    if (q1.size() == 0) begin
                        fail_now("s1 unexpected done");
                    end else begin
                        e = q1.pop_front();
                        cmp("s1 tt1/tt2/errs/pass", {20'd0, if1.tt1, if1.tt2, if1.errs, if1.pass},
                            {20'd0, e.tt1, e.tt2, e.errs, e.pass});
                        cmp("s1 done cycle", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp("s0 xy/busy/done", {28'd0, if0.x, if0.y, if0.busy, if0.done},
                    {28'd0, stream_exp(act0, cyc - c0_0, 1)});
                if (if0.done) begin
                    if (q0.size() == 0) begin
                        fail_now("s0 unexpected done");
                    end else begin
                        e = q0.pop_front();
                        cmp("s0 tt1/tt2/errs/pass", {20'd0, if0.tt1, if0.tt2, if0.errs, if0.pass},
                            {20'd0, e.tt1, e.tt2, e.errs, e.pass});
                        cmp("s0 done cycle", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (q1.size() == 0 && q0.size() == 0 && rem1 == 0 && rem0 == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_idle timeout, done never arrived");
    endtask

    task automatic sweep(logic [3:0] a, logic [3:0] b);
        @(negedge clk);
        m1 = a;
        m2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero(string nm);
        cmp({nm, " s1 all-zero"},
            {17'd0, if1.x, if1.y, if1.busy, if1.done, if1.pass, if1.tt1, if1.tt2, if1.errs}, 32'd0);
        cmp({nm, " s0 all-zero"},
            {17'd0, if0.x, if0.y, if0.busy, if0.done, if0.pass, if0.tt1, if0.tt2, if0.errs}, 32'd0);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        #1;
        check_zero("power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct function block.
        sweep(4'b0000, 4'b0000);
        // s1 stuck at 0, then s2 inverted.
        sweep(4'b1011, 4'b0000);
        sweep(4'b0000, 4'b1111);

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start held high: back-to-back sweeps, never restarted mid-sweep.
        @(negedge clk);
        m1 = 4'b0010;
        m2 = 4'b0100;
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset after the second sample edge of the SETTLE=1 sweeper.
        @(negedge clk);
        m1 = 4'b0110;
        m2 = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid-sweep reset");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(4'b0000, 4'b0000);

        // Random fault patterns.
        repeat (24) begin
            sweep(4'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
